pipelined_cla_adder: RTL and testbench

//   Parametrised carry-lookahead adder with a 2-stage pipeline and valid/ready handshake.

---
 rtl/pipelined_cla_adder.sv | 139 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Optional signed-overflow and zero flags are built when CLA_FLAGS_EN is defined.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef CLA_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  localparam int unsigned GROUPS = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH == 0) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of 4");
  end

  // Full 4-bit lookahead: returns {c4, c3, c2, c1} from group p/g and carry-in.
  function automatic logic [3:0] group_carries(input logic [3:0] p4,
                                               input logic [3:0] g4,
                                               input logic       cin);
    logic c1, c2, c3, c4;
    c1 = g4[0] | (p4[0] & cin);
    c2 = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cin);
    c3 = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
       | (p4[2] & p4[1] & p4[0] & cin);
    c4 = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
       | (p4[3] & p4[2] & p4[1] & g4[0])
       | (p4[3] & p4[2] & p4[1] & p4[0] & cin);
    return {c4, c3, c2, c1};
  endfunction

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic [WIDTH-1:0] c_c;
  logic             cout_c;
  logic             ripple;
  logic [3:0]       grp;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_c;
  logic             s1_cout;
  logic [WIDTH-1:0] sum_nxt;

  // Pipeline advance: stage 2 moves when empty or drained, stage 1 when stage 2 can take it.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Lookahead within each group, rippling group carry-outs to the next group.
  always_comb begin
    p_c    = a ^ b;
    g_c    = a & b;
    c_c    = '0;
    grp    = '0;
    ripple = carry_in;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      grp              = group_carries(p_c[4*k +: 4], g_c[4*k +: 4], ripple);
      c_c[4*k]         = ripple;
      c_c[4*k+1 +: 3]  = grp[2:0];
      ripple           = grp[3];
    end
    cout_c = ripple;
  end

  // Stage 1: propagate bits and per-bit carries.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_c     <= '0;
      s1_cout  <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      s1_p     <= p_c;
      s1_c     <= c_c;
      s1_cout  <= cout_c;
    end
  end

  assign sum_nxt = s1_p ^ s1_c;

  // Stage 2: final sum and carry-out.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      sum       <= sum_nxt;
      carry_out <= s1_cout;
    end
  end

`ifdef CLA_FLAGS_EN
  localparam int unsigned MSB = WIDTH - 1;

  logic s1_a_msb;
  logic s1_b_msb;

  // Operand sign bits travel with stage 1 so overflow can be formed after the sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (adv1) begin
      s1_a_msb <= a[MSB];
      s1_b_msb <= b[MSB];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (adv2) begin
      overflow <= (s1_a_msb ~^ s1_b_msb) & (sum_nxt[MSB] ^ s1_a_msb);
      zero     <= ~|sum_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed corner cases plus a
// randomized handshake stream scored against an arithmetic reference queue.
module tb_pipelined_cla_adder;

  localparam int unsigned W = 32;
  localparam int          N_RAND = 10000;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef CLA_FLAGS_EN
  logic         overflow;
  logic         zero;
`endif

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef CLA_FLAGS_EN
    ,
    .overflow  (overflow),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        mon_e;
  int           total = 0;
  int           bad = 0;
  int           consumed = 0;
  bit           hold_prev = 1'b0;
  logic [W:0]   prev_out;
  logic [W:0]   mon_ref;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_add(input beat_t e);
    return {1'b0, e.a} + {1'b0, e.b} + (W+1)'(e.ci);
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      default: return W'(t);
    endcase
  endfunction

  // Scoreboard: results must appear in acceptance order and hold while stalled.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold_stable", {carry_out, sum}, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 1, 0);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_ref = ref_add(mon_e);
          check("sum_vs_model", {carry_out, sum}, mon_ref);
`ifdef CLA_FLAGS_EN
          check("overflow_vs_model", overflow,
                (mon_e.a[W-1] == mon_e.b[W-1]) && (mon_ref[W-1] != mon_e.a[W-1]));
          check("zero_vs_model", zero, mon_ref[W-1:0] == '0);
`endif
          consumed++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{a: a, b: b, ci: carry_in});
      hold_prev = out_valid && !out_ready;
      prev_out  = {carry_out, sum};
    end
  end

  // Single beat with out_ready high: checks the exact 2-cycle latency.
  task automatic one_beat(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tci, input logic [W-1:0] esum, input logic eco);
    @(posedge clk); #1;
    a = ta; b = tb; carry_in = tci; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("latency_1cyc_not_valid", out_valid, 0);
    @(posedge clk); #1;
    check("latency_2cyc_valid", out_valid, 1);
    check("directed_sum", sum, esum);
    check("directed_carry", carry_out, eco);
  endtask

  task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
    a = ta; b = tb; carry_in = tci; in_valid = 1'b1;
  endtask

  task automatic drain(input string tag);
    int i;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int c0;
    int sent;
    bit acc;
    bit got;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; carry_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_carry", carry_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);

    one_beat(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0);
    one_beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
`ifdef CLA_FLAGS_EN
    check("zero_flag_full_chain", zero, 1);
`endif
    one_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
`ifdef CLA_FLAGS_EN
    check("overflow_flag", overflow, 1);
`endif
    one_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    drain("drain_directed");

    // Back-to-back stream stalled by the consumer after two beats.
    c0 = consumed;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_beat(32'd10, 32'd1, 1'b0);
    @(posedge clk); #1;
    drive_beat(32'd20, 32'd2, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_beat(32'd30, 32'd3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("in_ready_full", in_ready, 0);
      check("out_valid_full", out_valid, 1);
      check("held_first_result", sum, 32'd11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    check("third_beat_accepted", got, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("drain_stall");
    check("stall_result_count", consumed - c0, 3);

    // Reset with two beats in flight: they must vanish.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_beat(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(posedge clk); #1;
    drive_beat(32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_sum", sum, 0);
    check("flush_carry", carry_out, 0);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_result", out_valid, 0);
    end

    // Randomized stream with random producer and consumer throttling.
    c0 = consumed;
    sent = 0;
    for (int cyc = 0; cyc < 60000 && sent < N_RAND; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        if (sent < N_RAND && ($urandom % 4) != 0)
          drive_beat(rand_word(), rand_word(), 1'($urandom % 2));
        else
          in_valid = 1'b0;
      end
      out_ready = ($urandom % 4) != 0;
    end
    check("random_beats_sent", sent, N_RAND);
    drain("drain_random");
    check("random_result_count", consumed - c0, sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
